// File: rtl/gpio_atr_clkgen_pkg.sv
// Shared constants for the ATR GPIO controller with a programmable RF-switch clock.
package gpio_atr_clkgen_pkg;

    // Register offsets relative to BASE on the settings bus
    localparam logic [7:0] REG_IDLE       = 8'd0;
    localparam logic [7:0] REG_RX         = 8'd1;
    localparam logic [7:0] REG_TX         = 8'd2;
    localparam logic [7:0] REG_FDX        = 8'd3;
    localparam logic [7:0] REG_DDR        = 8'd4;
    localparam logic [7:0] REG_ATR_DIS    = 8'd5;
    localparam logic [7:0] REG_CLK_PIN    = 8'd6;
    localparam logic [7:0] REG_CLK_STATE  = 8'd7;
    localparam logic [7:0] REG_HALF_PER   = 8'd8;
    localparam logic [7:0] REG_CTRL       = 8'd9;

    // ATR state, encoded as {tx, rx}
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RX   = 2'b01,
        ST_TX   = 2'b10,
        ST_FDX  = 2'b11
    } atr_state_t;

endpackage

// File: rtl/gpio_atr_clkgen_clk_div.sv
// Programmable half-period divider producing the RF-switch clock.
module gpio_clk_div #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_enable,
    input  logic                 i_restart,
    input  logic [DIV_WIDTH-1:0] i_half_period,
    output logic                 o_gen_clk
);

    logic [DIV_WIDTH-1:0] r_cnt;
    logic                 r_gen_clk;

    assign o_gen_clk = r_gen_clk;

    // Count 0..half_period and toggle on wrap; restart wins over the toggle.
    // The >= compare means a shrunken half_period never causes a long wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_gen_clk <= 1'b0;
        end else if (i_restart || !i_enable) begin
            r_cnt     <= '0;
            r_gen_clk <= 1'b0;
        end else if (r_cnt >= i_half_period) begin
            r_cnt     <= '0;
            r_gen_clk <= ~r_gen_clk;
        end else begin
            r_cnt     <= r_cnt + {{(DIV_WIDTH-1){1'b0}}, 1'b1};
            r_gen_clk <= r_gen_clk;
        end
    end

endmodule

// File: rtl/setting_reg.sv
// Single settings-bus register: captures the bus data when its address is strobed.
module setting_reg #(
    parameter logic [7:0]       MY_ADDR  = 8'd0,
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] AT_RESET = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             strobe,
    input  logic [7:0]       addr,
    input  logic [31:0]      in,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] r_out;
    logic [31:0]      w_in_full;
    logic             w_unused_in;

    assign w_in_full   = in;
    assign w_unused_in = ^w_in_full;
    assign out         = r_out;

    // Capture the low WIDTH data bits on a matching strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out <= AT_RESET;
        end else if (strobe && (addr == MY_ADDR)) begin
            r_out <= w_in_full[WIDTH-1:0];
        end else begin
            r_out <= r_out;
        end
    end

endmodule

// File: rtl/gpio_atr_clkgen.sv
// ATR GPIO controller: per-state static pin values, optionally replaced by a
// divided clock on selected pins in selected ATR states.
module gpio_atr_clkgen
    import gpio_atr_clkgen_pkg::*;
#(
    parameter logic [7:0] BASE         = 8'd0,
    parameter int         WIDTH        = 32,
    parameter int         DIV_WIDTH    = 16,
    parameter logic [WIDTH-1:0] DEFAULT_DDR  = '0,
    parameter logic [WIDTH-1:0] DEFAULT_IDLE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set_stb,
    input  logic [7:0]       set_addr,
    input  logic [31:0]      set_data,
    input  logic             rx,
    input  logic             tx,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_ddr,
    output logic [WIDTH-1:0] gpio_sw_rb,
    output logic             gen_clk
);

    logic [WIDTH-1:0]     w_idle, w_rx, w_tx, w_fdx, w_ddr, w_atr_dis, w_clk_pin;
    logic [3:0]           w_clk_state;
    logic [DIV_WIDTH-1:0] w_half_per;
    logic [1:0]           w_ctrl;

    setting_reg #(.MY_ADDR(BASE + REG_IDLE),      .WIDTH(WIDTH), .AT_RESET(DEFAULT_IDLE))
        u_idle (.clk(clk), .rst(reset), .strobe(set_stb), .addr(set_addr), .in(set_data), .out(w_idle));
    setting_reg #(.MY_ADDR(BASE + REG_RX),        .WIDTH(WIDTH), .AT_RESET('0))
        u_rx   (.clk(clk), .rst(reset), .strobe(set_stb), .addr(set_addr), .in(set_data), .out(w_rx));
    setting_reg #(.MY_ADDR(BASE + REG_TX),        .WIDTH(WIDTH), .AT_RESET('0))
        u_tx   (.clk(clk), .rst(reset), .strobe(set_stb), .addr(set_addr), .in(set_data), .out(w_tx));
    setting_reg #(.MY_ADDR(BASE + REG_FDX),       .WIDTH(WIDTH), .AT_RESET('0))
        u_fdx  (.clk(clk), .rst(reset), .strobe(set_stb), .addr(set_addr), .in(set_data), .out(w_fdx));
    setting_reg #(.MY_ADDR(BASE + REG_DDR),       .WIDTH(WIDTH), .AT_RESET(DEFAULT_DDR))
        u_ddr  (.clk(clk), .rst(reset), .strobe(set_stb), .addr(set_addr), .in(set_data), .out(w_ddr));
    setting_reg #(.MY_ADDR(BASE + REG_ATR_DIS),   .WIDTH(WIDTH), .AT_RESET('0))
        u_adis (.clk(clk), .rst(reset), .strobe(set_stb), .addr(set_addr), .in(set_data), .out(w_atr_dis));
    setting_reg #(.MY_ADDR(BASE + REG_CLK_PIN),   .WIDTH(WIDTH), .AT_RESET('0))
        u_cpin (.clk(clk), .rst(reset), .strobe(set_stb), .addr(set_addr), .in(set_data), .out(w_clk_pin));
    setting_reg #(.MY_ADDR(BASE + REG_CLK_STATE), .WIDTH(4), .AT_RESET(4'h0))
        u_cst  (.clk(clk), .rst(reset), .strobe(set_stb), .addr(set_addr), .in(set_data), .out(w_clk_state));
    setting_reg #(.MY_ADDR(BASE + REG_HALF_PER),  .WIDTH(DIV_WIDTH), .AT_RESET('0))
        u_hp   (.clk(clk), .rst(reset), .strobe(set_stb), .addr(set_addr), .in(set_data), .out(w_half_per));
    setting_reg #(.MY_ADDR(BASE + REG_CTRL),      .WIDTH(2), .AT_RESET(2'b00))
        u_ctrl (.clk(clk), .rst(reset), .strobe(set_stb), .addr(set_addr), .in(set_data), .out(w_ctrl));

    atr_state_t       r_state_d;
    atr_state_t       w_state_in;
    logic             w_div_wr;
    logic             w_restart;
    logic             w_gen_clk;
    logic [WIDTH-1:0] w_static;
    logic [WIDTH-1:0] w_ogpio_next;
    logic [WIDTH-1:0] r_ogpio;
    logic [WIDTH-1:0] r_gpio_out;
    logic [WIDTH-1:0] r_gpio_ddr;
    logic [WIDTH-1:0] r_igpio;
    logic [WIDTH-1:0] r_sw_rb;

    assign w_state_in = atr_state_t'({tx, rx});

    // A divider-config write restarts it on the same edge the value lands;
    // a state change restarts it on the edge state_d takes the new state.
    assign w_div_wr  = set_stb && ((set_addr == (BASE + REG_HALF_PER)) ||
                                   (set_addr == (BASE + REG_CTRL)));
    assign w_restart = w_div_wr || (w_ctrl[0] && (w_state_in != r_state_d));

    gpio_clk_div #(.DIV_WIDTH(DIV_WIDTH)) u_div (
        .clk           (clk),
        .rst           (reset),
        .i_enable      (w_ctrl[1]),
        .i_restart     (w_restart),
        .i_half_period (w_half_per),
        .o_gen_clk     (w_gen_clk)
    );

    // Register the ATR run signals; rx and tx moving together is one change
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state_d <= ST_IDLE;
        end else begin
            r_state_d <= w_state_in;
        end
    end

    // Select each pin: ATR-disabled pins use idle, clocked pins use gen_clk
    always_comb begin
        w_static     = w_idle;
        w_ogpio_next = '0;
        case (r_state_d)
            ST_IDLE: w_static = w_idle;
            ST_RX:   w_static = w_rx;
            ST_TX:   w_static = w_tx;
            ST_FDX:  w_static = w_fdx;
            default: w_static = w_idle;
        endcase
        for (int i = 0; i < WIDTH; i++) begin
            if (w_atr_dis[i]) begin
                w_ogpio_next[i] = w_idle[i];
            end else if (w_clk_pin[i] && w_clk_state[r_state_d]) begin
                w_ogpio_next[i] = w_gen_clk;
            end else begin
                w_ogpio_next[i] = w_static[i];
            end
        end
    end

    // Output pipeline and software readback
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ogpio    <= '0;
            r_gpio_out <= '0;
            r_gpio_ddr <= '0;
            r_igpio    <= '0;
            r_sw_rb    <= '0;
        end else begin
            r_ogpio    <= w_ogpio_next;
            r_gpio_out <= r_ogpio;
            r_gpio_ddr <= w_ddr;
            r_igpio    <= gpio_in;
            r_sw_rb    <= (r_gpio_ddr & r_gpio_out) | (~r_gpio_ddr & r_igpio);
        end
    end

    assign gpio_out   = r_gpio_out;
    assign gpio_ddr   = r_gpio_ddr;
    assign gpio_sw_rb = r_sw_rb;
    assign gen_clk    = w_gen_clk;

endmodule

// File: tb/tb_gpio_atr_clkgen.sv
// Directed, table-driven bench for gpio_atr_clkgen.
module tb_gpio_atr_clkgen;

    logic        clk;
    logic        reset;
    logic        set_stb;
    logic [7:0]  set_addr;
    logic [31:0] set_data;
    logic        rx;
    logic        tx;
    logic [31:0] gpio_in;
    logic [31:0] gpio_out;
    logic [31:0] gpio_ddr;
    logic [31:0] gpio_sw_rb;
    logic        gen_clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        rx;
        logic        tx;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[6];
    vec_t dis_tbl[4];

    gpio_atr_clkgen #(
        .BASE(8'd0), .WIDTH(32), .DIV_WIDTH(16),
        .DEFAULT_DDR(32'h0000_00FF), .DEFAULT_IDLE(32'h0000_000F)
    ) dut (
        .clk(clk), .reset(reset), .set_stb(set_stb), .set_addr(set_addr),
        .set_data(set_data), .rx(rx), .tx(tx), .gpio_in(gpio_in),
        .gpio_out(gpio_out), .gpio_ddr(gpio_ddr), .gpio_sw_rb(gpio_sw_rb),
        .gen_clk(gen_clk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        set_stb  = 1'b1;
        set_addr = a;
        set_data = d;
        tick();
        set_stb  = 1'b0;
        set_addr = 8'hFF;
        set_data = 32'h0;
    endtask

    task automatic settle3();
        tick(); tick(); tick();
    endtask

    initial begin
        tbl[0] = '{rx: 1'b1, tx: 1'b0, exp: 32'h0000_00A5};
        tbl[1] = '{rx: 1'b1, tx: 1'b1, exp: 32'h0000_00C3};
        tbl[2] = '{rx: 1'b0, tx: 1'b1, exp: 32'h0000_003C};
        tbl[3] = '{rx: 1'b0, tx: 1'b0, exp: 32'h0000_000F};
        tbl[4] = '{rx: 1'b1, tx: 1'b1, exp: 32'h0000_00C3};
        tbl[5] = '{rx: 1'b0, tx: 1'b0, exp: 32'h0000_000F};
        // atr_disable on pin 0: pin 0 = idle[0] = 1 in every state
        dis_tbl[0] = '{rx: 1'b0, tx: 1'b0, exp: 32'h0000_000F};
        dis_tbl[1] = '{rx: 1'b1, tx: 1'b0, exp: 32'h0000_00A5};
        dis_tbl[2] = '{rx: 1'b0, tx: 1'b1, exp: 32'h0000_003D};
        dis_tbl[3] = '{rx: 1'b1, tx: 1'b1, exp: 32'h0000_00C3};

        reset = 1'b1; set_stb = 1'b0; set_addr = 8'hFF; set_data = 32'h0;
        rx = 1'b0; tx = 1'b0; gpio_in = 32'h0;

        // Reset state
        tick(); tick();
        chk("rst_out",   gpio_out,   32'h0);
        chk("rst_ddr",   gpio_ddr,   32'h0);
        chk("rst_rb",    gpio_sw_rb, 32'h0);
        chk("rst_gen",   {31'h0, gen_clk}, 32'h0);
        reset = 1'b0;
        tick();
        chk("rel1_out",  gpio_out,   32'h0);
        tick();
        chk("rel2_out",  gpio_out,   32'h0000_000F);
        chk("rel2_ddr",  gpio_ddr,   32'h0000_00FF);

        // rx edge latency: 3 clk
        wr(8'd1, 32'h0000_00A5);
        rx = 1'b1;
        tick(); chk("rx_lat1", gpio_out, 32'h0000_000F);
        tick(); chk("rx_lat2", gpio_out, 32'h0000_000F);
        tick(); chk("rx_lat3", gpio_out, 32'h0000_00A5);
        rx = 1'b0;
        tick(); tick(); chk("idle_lat2", gpio_out, 32'h0000_00A5);
        tick();         chk("idle_lat3", gpio_out, 32'h0000_000F);

        // Settings write latency: 3 clk from the write edge
        wr(8'd0, 32'h0000_001F);
        tick(); chk("wr_lat2", gpio_out, 32'h0000_000F);
        tick(); chk("wr_lat3", gpio_out, 32'h0000_001F);
        wr(8'd0, 32'h0000_000F);
        wr(8'd10, 32'hFFFF_FFFF);   // unmapped address, ignored
        settle3();
        chk("bad_addr", gpio_out, 32'h0000_000F);

        // Static per-state table
        wr(8'd2, 32'h0000_003C);
        wr(8'd3, 32'h0000_00C3);
        for (int i = 0; i < 6; i++) begin
            rx = tbl[i].rx; tx = tbl[i].tx;
            settle3();
            chk($sformatf("state_tbl%0d", i), gpio_out, tbl[i].exp);
        end

        // Divider clocking pin 0 in rx only
        wr(8'd8, 32'd3);
        wr(8'd6, 32'h0000_0001);
        wr(8'd7, 32'h0000_0002);
        wr(8'd9, 32'h0000_0002);
        rx = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            tick();
            chk($sformatf("gen_k%0d", k), {31'h0, gen_clk}, 32'((k / 4) % 2));
            if (k >= 4)
                chk($sformatf("pin0_k%0d", k), gpio_out, 32'h0000_00A4 | 32'(((k - 2) / 4) % 2));
        end
        rx = 1'b0;
        settle3();
        chk("clk_idle", gpio_out, 32'h0000_000F);

        // Restart on state change, divider mid-count with gen_clk high
        wr(8'd9, 32'h0000_0003);
        for (int k = 1; k <= 5; k++) tick();
        chk("rs_pre", {31'h0, gen_clk}, 32'h1);
        tx = 1'b1;
        tick(); chk("rs_now", {31'h0, gen_clk}, 32'h0);
        tick(); tick(); tick();
        chk("rs_hold", {31'h0, gen_clk}, 32'h0);
        tick(); chk("rs_first", {31'h0, gen_clk}, 32'h1);
        tx = 1'b0;

        // atr_disable on pin 0 overrides the clock in all states
        wr(8'd5, 32'h0000_0001);
        wr(8'd7, 32'h0000_000F);
        for (int i = 0; i < 4; i++) begin
            rx = dis_tbl[i].rx; tx = dis_tbl[i].tx;
            settle3();
            for (int k = 0; k < 8; k++) begin
                chk($sformatf("adis_s%0d_k%0d", i, k), gpio_out, dis_tbl[i].exp);
                tick();
            end
        end
        rx = 1'b0; tx = 1'b0;
        wr(8'd5, 32'h0);
        wr(8'd6, 32'h0);

        // Readback: inputs when ddr=0, outputs when ddr=all ones
        wr(8'd4, 32'h0);
        tick(); tick();
        chk("ddr0", gpio_ddr, 32'h0);
        gpio_in = 32'h0000_005A;
        tick(); chk("rb_lat1", gpio_sw_rb, 32'h0);
        tick(); chk("rb_lat2", gpio_sw_rb, 32'h0000_005A);
        wr(8'd4, 32'hFFFF_FFFF);
        settle3();
        chk("ddr1", gpio_ddr, 32'hFFFF_FFFF);
        chk("rb_out", gpio_sw_rb, 32'h0000_000F);

        // Reset mid-pattern with the clock running in rx
        wr(8'd1, 32'h0000_00A5);
        wr(8'd6, 32'h0000_0001);
        wr(8'd7, 32'h0000_0002);
        rx = 1'b1;
        settle3(); settle3();
        chk("mid_pre", gpio_out & 32'hFFFF_FFFE, 32'h0000_00A4);
        reset = 1'b1;
        #1;
        chk("mid_out", gpio_out,   32'h0);
        chk("mid_ddr", gpio_ddr,   32'h0);
        chk("mid_rb",  gpio_sw_rb, 32'h0);
        chk("mid_gen", {31'h0, gen_clk}, 32'h0);
        rx = 1'b0;
        tick();
        reset = 1'b0;
        tick(); chk("post1_out", gpio_out, 32'h0);
        chk("post1_ddr", gpio_ddr, 32'h0000_00FF);
        tick(); chk("post2_out", gpio_out, 32'h0000_000F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
